// File: rtl/sample_stream_tx.sv
// Multi-channel sample streamer: snapshots N_CH samples on a sample_clk rising edge and
// emits 'C','H',id,data framed bytes to a uart_tx. Define STREAM_CHECKSUM_EN to append an XOR byte.
module sample_stream_tx #(
   parameter int W        = 16,
   parameter int N_CH     = 4,
   parameter int DECIMATE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_clk,
   input  logic [N_CH*W-1:0] sample_in,
   input  logic              enable,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic              frame_led,
   output logic [7:0]        overrun_cnt,
   output logic              active
);

   localparam int NB    = (W + 7) / 8;
   localparam int BLK   = 3 + NB;
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int POS_W = $clog2(BLK);
   localparam int DEC_W = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_t;

   state_t             state;
   logic               sclk_q;
   logic [DEC_W-1:0]   dec_cnt;
   logic               edge_ev;
   logic               take;
   logic               start_frame;
   logic [CH_W-1:0]    ch_idx, nxt_ch;
   logic [POS_W-1:0]   pos_idx, nxt_pos;
   logic               last_byte;
   logic [7:0]         nxt_byte;
   logic [W-1:0]       snap [N_CH];
   logic signed [W-1:0]    snap_sel;
   logic signed [NB*8-1:0] ext;
   logic [NB*8-1:0]    shifted;
   int                 data_sh;
`ifdef STREAM_CHECKSUM_EN
   logic [7:0]         csum;
   logic               ck_phase, nxt_ck;
`endif

   assign edge_ev     = sample_clk & ~sclk_q;
   assign take        = edge_ev && (dec_cnt == '0);
   assign start_frame = take && enable && (state == IDLE);

   // Position of the byte that follows the one currently on tx_data.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      nxt_ch  = ch_idx;
      nxt_pos = pos_idx + 1'b1;
`ifdef STREAM_CHECKSUM_EN
      nxt_ck  = ck_phase;
`endif
      if (pos_idx == POS_W'(BLK - 1)) begin
         nxt_pos = '0;
         if (ch_idx != CH_W'(N_CH - 1))
            nxt_ch = ch_idx + 1'b1;
`ifdef STREAM_CHECKSUM_EN
         else
            nxt_ck = 1'b1;
`endif
      end
   end

`ifdef STREAM_CHECKSUM_EN
   assign last_byte = ck_phase;
`else
   assign last_byte = (ch_idx == CH_W'(N_CH - 1)) && (pos_idx == POS_W'(BLK - 1));
`endif

   always_comb begin
      snap_sel = snap[nxt_ch];
      ext      = (NB*8)'(snap_sel);
      data_sh  = 8 * (NB + 2 - int'(nxt_pos));
      shifted  = ext >> data_sh;
      if (nxt_pos == POS_W'(0))
         nxt_byte = 8'h43;
      else if (nxt_pos == POS_W'(1))
         nxt_byte = 8'h48;
      else if (nxt_pos == POS_W'(2))
         nxt_byte = 8'h30 + 8'(nxt_ch);
      else
         nxt_byte = shifted[7:0];
`ifdef STREAM_CHECKSUM_EN
      if (nxt_ck)
         nxt_byte = csum;
`endif
   end

   // NOTE: the snapshot is pure datapath, written before it is ever read, so it carries no reset.
   always_ff @(posedge clk) begin
      if (start_frame) begin
         for (int k = 0; k < N_CH; k++)
            snap[k] <= sample_in[k*W +: W];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         sclk_q      <= 1'b0;
         dec_cnt     <= '0;
         tx_start    <= 1'b0;
         tx_data     <= 8'h00;
         frame_led   <= 1'b0;
         overrun_cnt <= 8'h00;
         active      <= 1'b0;
         ch_idx      <= '0;
         pos_idx     <= '0;
`ifdef STREAM_CHECKSUM_EN
         csum        <= 8'h00;
         ck_phase    <= 1'b0;
`endif
      end else begin
         sclk_q <= sample_clk;
         if (edge_ev)
            dec_cnt <= (dec_cnt == DEC_W'(DECIMATE - 1)) ? '0 : dec_cnt + 1'b1;
         if (take && active && (overrun_cnt != 8'hFF))
            overrun_cnt <= overrun_cnt + 8'd1;

         case (state)
            IDLE: begin
               if (start_frame) begin
                  active   <= 1'b1;
                  ch_idx   <= '0;
                  pos_idx  <= '0;
                  tx_data  <= 8'h43;
                  tx_start <= ~tx_busy;
`ifdef STREAM_CHECKSUM_EN
                  csum     <= 8'h00;
                  ck_phase <= 1'b0;
`endif
                  state    <= LOAD;
               end
            end
            // tx_start is decided one cycle ahead so it leaves a flop as a clean one-cycle pulse.
            LOAD: begin
               if (tx_start) begin
                  tx_start <= 1'b0;
`ifdef STREAM_CHECKSUM_EN
                  csum     <= csum ^ tx_data;
`endif
                  state    <= WAIT_ACK;
               end else begin
                  tx_start <= ~tx_busy;
               end
            end
            WAIT_ACK: begin
               if (tx_busy)
                  state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  if (last_byte) begin
                     frame_led <= ~frame_led;
                     active    <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     ch_idx   <= nxt_ch;
                     pos_idx  <= nxt_pos;
`ifdef STREAM_CHECKSUM_EN
                     ck_phase <= nxt_ck;
`endif
                     tx_data  <= nxt_byte;
                     tx_start <= 1'b1;
                     state    <= LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sample_stream_tx.sv
// Bench for sample_stream_tx: two instances (16b x4 ch, 12b x1 ch with decimation 3), a uart_tx
// model capturing bytes, literal vector tables, corner sequences and a randomized frame model.
module tb_sample_stream_tx;
   localparam int WA = 16, NA = 4, DA = 1;
   localparam int WB = 12, NCB = 1, DB = 3;
`ifdef STREAM_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif
   localparam int LEN_A = NA * 5 + CK;
   localparam int LEN_B = NCB * 5 + CK;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              sclk_a = 1'b0, en_a = 1'b0, busy_a = 1'b0, hold_a = 1'b0;
   logic              start_a, led_a, act_a;
   logic [NA*WA-1:0]  sin_a = '0;
   logic [7:0]        data_a, ovr_a;
   logic              sclk_b = 1'b0, en_b = 1'b0, busy_b = 1'b0, hold_b = 1'b0;
   logic              start_b, led_b, act_b;
   logic [NCB*WB-1:0] sin_b = '0;
   logic [7:0]        data_b, ovr_b;

   int checks = 0, failures = 0;
   int cnt_a = 0, cnt_b = 0, eb_cnt = 0;
   logic [7:0] cap_a[$], cap_b[$], exp_q[$];

   sample_stream_tx #(.W(WA), .N_CH(NA), .DECIMATE(DA)) dut_a (
      .clk(clk), .rst(rst), .sample_clk(sclk_a), .sample_in(sin_a), .enable(en_a),
      .tx_start(start_a), .tx_data(data_a), .tx_busy(busy_a), .frame_led(led_a),
      .overrun_cnt(ovr_a), .active(act_a));

   sample_stream_tx #(.W(WB), .N_CH(NCB), .DECIMATE(DB)) dut_b (
      .clk(clk), .rst(rst), .sample_clk(sclk_b), .sample_in(sin_b), .enable(en_b),
      .tx_start(start_b), .tx_data(data_b), .tx_busy(busy_b), .frame_led(led_b),
      .overrun_cnt(ovr_b), .active(act_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // uart_tx model: accepts a byte on tx_start, stays busy for 10 cycles.
   always @(negedge clk) begin
      if (rst) begin
         cnt_a = 0;
         cnt_b = 0;
      end else begin
         if (start_a) begin
            check("a_start_while_busy", busy_a, 0);
            if (!busy_a) begin cap_a.push_back(data_a); cnt_a = 10; end
         end else if (cnt_a > 0) cnt_a--;
         if (start_b) begin
            check("b_start_while_busy", busy_b, 0);
            if (!busy_b) begin cap_b.push_back(data_b); cnt_b = 10; end
         end else if (cnt_b > 0) cnt_b--;
      end
      busy_a = hold_a || (cnt_a > 0);
      busy_b = hold_b || (cnt_b > 0);
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; sclk_a = 1'b0; sclk_b = 1'b0; hold_a = 1'b0; hold_b = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cap_a.delete(); cap_b.delete();
      eb_cnt = 0;
      @(negedge clk);
   endtask

   task automatic edge_a();
      @(negedge clk) sclk_a = 1'b1;
      @(negedge clk) sclk_a = 1'b0;
   endtask

   task automatic edge_b();
      @(negedge clk) sclk_b = 1'b1;
      @(negedge clk) sclk_b = 1'b0;
      eb_cnt++;
   endtask

   task automatic wait_idle(input int inst, input int n, input string tag);
      int t = 0;
      while (t < 3000 && (inst == 0 ? (cap_a.size() < n || act_a) : (cap_b.size() < n || act_b))) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_timeout"}, t < 3000, 1);
   endtask

   task automatic wait_bytes_a(input int n, input string tag);
      int t = 0;
      while (cap_a.size() < n && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_timeout"}, t < 3000, 1);
   endtask

   task automatic add_checksum();
`ifdef STREAM_CHECKSUM_EN
      logic [7:0] x = 8'h00;
      foreach (exp_q[i]) x ^= exp_q[i];
      exp_q.push_back(x);
`endif
   endtask

   // Reference frame built straight from the byte rules with integer arithmetic.
   task automatic model_frame(input int w, input int nch, input logic [319:0] sin);
      int nb = (w + 7) / 8;
      exp_q.delete();
      for (int k = 0; k < nch; k++) begin
         logic [319:0] t;
         longint raw, v, e;
         t   = sin >> (k * w);
         raw = longint'(t[31:0]) & ((longint'(1) << w) - 1);
         v   = (raw >= (longint'(1) << (w - 1))) ? raw - (longint'(1) << w) : raw;
         e   = (v < 0) ? v + (longint'(1) << (8 * nb)) : v;
         exp_q.push_back(8'h43);
         exp_q.push_back(8'h48);
         exp_q.push_back(8'(48 + k));
         for (int i = 0; i < nb; i++)
            exp_q.push_back(8'((e >> (8 * (nb - 1 - i))) & 255));
      end
      add_checksum();
   endtask

   task automatic cmp_frame(input int inst, input string tag);
      int n = exp_q.size();
      int got_n = (inst == 0) ? cap_a.size() : cap_b.size();
      check({tag, "_len"}, got_n, n);
      for (int i = 0; i < n && i < got_n; i++)
         check($sformatf("%s_byte%0d", tag, i), (inst == 0) ? cap_a[i] : cap_b[i], exp_q[i]);
      if (inst == 0) cap_a.delete(); else cap_b.delete();
   endtask

   typedef struct { logic [63:0] sin; logic [63:0] data; } vec_a_t;
   typedef struct { logic [11:0] sin; logic [15:0] data; } vec_b_t;
   vec_a_t va[3];
   vec_b_t vb[4];

   initial begin
      logic led_exp;
      int bad, hi, frames;
      logic take;

      va[0] = '{64'h8000_0001_ABCD_1234, 64'h1234_ABCD_0001_8000};
      va[1] = '{64'h00FF_0100_7FFF_FFFF, 64'hFFFF_7FFF_0100_00FF};
      va[2] = '{64'h5A5A_0000_C3C3_0F0F, 64'h0F0F_C3C3_0000_5A5A};
      vb[0] = '{12'h800, 16'hF800};
      vb[1] = '{12'h7FF, 16'h07FF};
      vb[2] = '{12'h001, 16'h0001};
      vb[3] = '{12'hFFF, 16'hFFFF};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tx_start", start_a, 0);
      check("rst_tx_data", data_a, 8'h00);
      check("rst_led", led_a, 0);
      check("rst_overrun", ovr_a, 0);
      check("rst_active", act_a, 0);
      check("rst_active_b", act_b, 0);
      rst = 1'b0;
      @(negedge clk);

      // Literal vectors, 16-bit x 4 channels
      led_exp = 1'b0;
      en_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sin_a = va[i].sin;
         edge_a();
         check($sformatf("t1_latency%0d", i), start_a, 1);
         wait_idle(0, LEN_A, "t1");
         exp_q.delete();
         for (int k = 0; k < NA; k++) begin
            exp_q.push_back(8'h43);
            exp_q.push_back(8'h48);
            exp_q.push_back(8'(8'h30 + k));
            exp_q.push_back(va[i].data[63-16*k -: 8]);
            exp_q.push_back(va[i].data[55-16*k -: 8]);
         end
         add_checksum();
         cmp_frame(0, $sformatf("t1v%0d", i));
         led_exp = ~led_exp;
         check("t1_led", led_a, led_exp);
         check("t1_active", act_a, 0);
      end

      // Literal vectors, 12-bit sign extension, decimation 3
      do_reset();
      en_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sin_b = vb[i].sin;
         edge_b();
         wait_idle(1, LEN_B, "t2");
         exp_q.delete();
         exp_q.push_back(8'h43); exp_q.push_back(8'h48); exp_q.push_back(8'h30);
         exp_q.push_back(vb[i].data[15:8]);
         exp_q.push_back(vb[i].data[7:0]);
         add_checksum();
         cmp_frame(1, $sformatf("t2v%0d", i));
         edge_b();
         edge_b();
         repeat (20) @(negedge clk);
         check("t2_skip_bytes", cap_b.size(), 0);
         check("t2_skip_active", act_b, 0);
      end

      // Decimation: 9 edges -> frames on edges 1, 4, 7
      do_reset();
      frames = 0;
      for (int e = 1; e <= 9; e++) begin
         sin_b = 12'($urandom);
         edge_b();
         check($sformatf("t3_start_e%0d", e), start_b, (e % 3 == 1));
         if (e % 3 == 1) begin
            wait_idle(1, LEN_B, "t3");
            model_frame(WB, NCB, 320'(sin_b));
            cmp_frame(1, "t3");
            frames++;
         end else begin
            repeat (30) @(negedge clk);
         end
      end
      check("t3_frames", frames, 3);
      check("t3_bytes_left", cap_b.size(), 0);
      check("t3_overrun", ovr_b, 0);

      // Overrun mid-frame keeps in-flight data; saturation at 255
      do_reset();
      sin_a = 64'h1111_2222_3333_4444;
      edge_a();
      wait_bytes_a(3, "t4_mid");
      sin_a = 64'hDEAD_BEEF_CAFE_F00D;
      edge_a();
      check("t4_overrun1", ovr_a, 1);
      wait_idle(0, LEN_A, "t4");
      model_frame(WA, NA, 320'(64'h1111_2222_3333_4444));
      cmp_frame(0, "t4");
      hold_a = 1'b1;
      sin_a = 64'h0123_4567_89AB_CDEF;
      edge_a();
      repeat (300) edge_a();
      check("t4_saturate", ovr_a, 255);
      hold_a = 1'b0;
      wait_idle(0, LEN_A, "t4s");
      model_frame(WA, NA, 320'(64'h0123_4567_89AB_CDEF));
      cmp_frame(0, "t4s");

      // Busy held after the edge
      do_reset();
      hold_a = 1'b1;
      sin_a = 64'h7654_3210_FEDC_BA98;
      edge_a();
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (start_a !== 1'b0 || data_a !== 8'h43) bad++;
      end
      check("t5_held_cycles_bad", bad, 0);
      check("t5_data", data_a, 8'h43);
      hold_a = 1'b0;
      hi = 0;
      repeat (6) begin
         @(negedge clk);
         if (start_a) hi++;
      end
      check("t5_pulse_len", hi, 1);
      wait_idle(0, LEN_A, "t5");
      model_frame(WA, NA, 320'(64'h7654_3210_FEDC_BA98));
      cmp_frame(0, "t5");

      // Reset mid-frame
      do_reset();
      sin_a = 64'hAAAA_5555_0F0F_F0F0;
      edge_a();
      wait_bytes_a(2, "t6_a");
      edge_a();
      wait_bytes_a(5, "t6_b");
      check("t6_pre_overrun", ovr_a, 1);
      @(negedge clk) rst = 1'b1;
      #1;
      check("t6_rst_start", start_a, 0);
      check("t6_rst_active", act_a, 0);
      check("t6_rst_overrun", ovr_a, 0);
      check("t6_rst_data", data_a, 8'h00);
      @(negedge clk) rst = 1'b0;
      cap_a.delete();
      @(negedge clk);
      check("t6_idle_after", act_a, 0);
      sin_a = 64'h0000_FFFF_8001_7FFE;
      edge_a();
      check("t6_restart", start_a, 1);
      check("t6_first_byte", data_a, 8'h43);
      wait_idle(0, LEN_A, "t6");
      model_frame(WA, NA, 320'(64'h0000_FFFF_8001_7FFE));
      cmp_frame(0, "t6");

      // enable dropped mid-frame: frame completes, next edge ignored
      sin_a = 64'h1357_9BDF_2468_ACE0;
      edge_a();
      wait_bytes_a(3, "t7_mid");
      en_a = 1'b0;
      wait_idle(0, LEN_A, "t7");
      model_frame(WA, NA, 320'(64'h1357_9BDF_2468_ACE0));
      cmp_frame(0, "t7");
      edge_a();
      repeat (20) @(negedge clk);
      check("t7_no_frame", cap_a.size(), 0);
      check("t7_no_active", act_a, 0);
      check("t7_no_overrun", ovr_a, 0);

      // Randomized frames against the model
      do_reset();
      for (int r = 0; r < 8; r++) begin
         sin_a = {$urandom, $urandom};
         en_a  = ($urandom_range(0, 3) != 0);
         edge_a();
         if (en_a) begin
            wait_idle(0, LEN_A, "ra");
            model_frame(WA, NA, 320'(sin_a));
            cmp_frame(0, $sformatf("ra%0d", r));
         end else begin
            repeat (20) @(negedge clk);
            check("ra_disabled_bytes", cap_a.size(), 0);
         end
      end
      for (int r = 0; r < 9; r++) begin
         sin_b = 12'($urandom);
         en_b  = ($urandom_range(0, 3) != 0);
         take  = (eb_cnt % DB == 0);
         edge_b();
         if (take && en_b) begin
            wait_idle(1, LEN_B, "rb");
            model_frame(WB, NCB, 320'(sin_b));
            cmp_frame(1, $sformatf("rb%0d", r));
         end else begin
            repeat (20) @(negedge clk);
            check("rb_no_bytes", cap_b.size(), 0);
         end
      end
      check("r_overrun_a", ovr_a, 0);
      check("r_overrun_b", ovr_b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
